// File: rtl/c_demux_split2_d_sync.sv
// Clocked 2-way drive/free demultiplexer: one upstream token is steered to out0 or out1
// and held until that output frees it. Optional BUSY watchdog under `SPLIT_TIMEOUT_EN`.
module c_demux_split2_d_sync #(
   parameter int DATA_WIDTH  = 128,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_drive,
   input  logic                  i_sel,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_free,
   output logic                  o_drive0,
   input  logic                  i_free0,
   output logic [DATA_WIDTH-1:0] o_data0,
   output logic                  o_drive1,
   input  logic                  i_free1,
   output logic [DATA_WIDTH-1:0] o_data1,
   output logic                  o_busy,
   output logic                  o_err,
   output logic [CNT_W-1:0]      o_cnt0,
   output logic [CNT_W-1:0]      o_cnt1,
   output logic                  o_timeout
);

   // Handshake: i_drive/o_driveX and i_freeX/o_free are single-cycle pulses; a token is
   // owned by the selected output from its drive pulse until that output's free pulse.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] data0_q, data0_d;
   logic [DATA_WIDTH-1:0] data1_q, data1_d;
   logic                  drive0_q, drive0_d;
   logic                  drive1_q, drive1_d;
   logic                  free_q, free_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      cnt0_q, cnt0_d;
   logic [CNT_W-1:0]      cnt1_q, cnt1_d;

`ifdef SPLIT_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            tmo_q, tmo_d;
   logic            wd_expired;

   assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));
   assign o_timeout  = tmo_q;
`else
   assign o_timeout  = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      data0_d  = data0_q;
      data1_d  = data1_q;
      drive0_d = 1'b0;
      drive1_d = 1'b0;
      free_d   = 1'b0;
      err_d    = err_q;
      cnt0_d   = cnt0_q;
      cnt1_d   = cnt1_q;
`ifdef SPLIT_TIMEOUT_EN
      wd_d     = wd_q;
      tmo_d    = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_drive) begin
               if (i_sel) begin
                  state_d  = BUSY1;
                  data1_d  = i_data;
                  drive1_d = 1'b1;
               end else begin
                  state_d  = BUSY0;
                  data0_d  = i_data;
                  drive0_d = 1'b1;
               end
`ifdef SPLIT_TIMEOUT_EN
               wd_d = '0;
`endif
            end
            // Any free with no token outstanding is a protocol violation.
            if (i_free0 || i_free1) err_d = 1'b1;
         end
         BUSY0: begin
            if (i_free0) begin
               state_d = IDLE;
               free_d  = 1'b1;
               cnt0_d  = cnt0_q + 1'b1;
`ifdef SPLIT_TIMEOUT_EN
            end else if (wd_expired) begin
               state_d = IDLE;
               free_d  = 1'b1;
               tmo_d   = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
`endif
            end
            if (i_free1 || i_drive) err_d = 1'b1;
         end
         BUSY1: begin
            if (i_free1) begin
               state_d = IDLE;
               free_d  = 1'b1;
               cnt1_d  = cnt1_q + 1'b1;
`ifdef SPLIT_TIMEOUT_EN
            end else if (wd_expired) begin
               state_d = IDLE;
               free_d  = 1'b1;
               tmo_d   = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
`endif
            end
            if (i_free0 || i_drive) err_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         data0_q  <= '0;
         data1_q  <= '0;
         drive0_q <= 1'b0;
         drive1_q <= 1'b0;
         free_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt0_q   <= '0;
         cnt1_q   <= '0;
`ifdef SPLIT_TIMEOUT_EN
         wd_q     <= '0;
         tmo_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         data0_q  <= data0_d;
         data1_q  <= data1_d;
         drive0_q <= drive0_d;
         drive1_q <= drive1_d;
         free_q   <= free_d;
         err_q    <= err_d;
         cnt0_q   <= cnt0_d;
         cnt1_q   <= cnt1_d;
`ifdef SPLIT_TIMEOUT_EN
         wd_q     <= wd_d;
         tmo_q    <= tmo_d;
`endif
      end
   end

   assign o_free   = free_q;
   assign o_drive0 = drive0_q;
   assign o_drive1 = drive1_q;
   assign o_data0  = data0_q;
   assign o_data1  = data1_q;
   assign o_busy   = (state_q != IDLE);
   assign o_err    = err_q;
   assign o_cnt0   = cnt0_q;
   assign o_cnt1   = cnt1_q;

endmodule
